// File: rtl/mealy_pkg.sv
// Shared encodings for the time-multiplexed 3-state Mealy channel scheduler.
package mealy_pkg;

  localparam int SW = 2;

  localparam logic [SW-1:0] ST_IDLE = 2'd0;
  localparam logic [SW-1:0] ST_S0   = 2'd1;
  localparam logic [SW-1:0] ST_S1   = 2'd2;

  localparam logic [SW-1:0] ST_RST  = ST_IDLE;

endpackage

// File: rtl/mealy_step.sv
// Combinational step of the shared Mealy function: (state, din) -> (next, dout).
module mealy_step
  import mealy_pkg::*;
(
  input  logic [SW-1:0] state_i,
  input  logic          din_i,
  output logic [SW-1:0] next_o,
  output logic          dout_o
);

  always_comb begin
    next_o = ST_IDLE;
    dout_o = 1'b0;
    case (state_i)
      ST_IDLE: next_o = ST_S0;
      ST_S0:   next_o = din_i ? ST_S1 : ST_S0;
      ST_S1: begin
        next_o = din_i ? ST_S0 : ST_S1;
        dout_o = 1'b1;
      end
      default: next_o = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mealy_ch_scheduler.sv
// Round-robin scheduler sharing one Mealy step across NCH channel contexts.
//   state | meaning
//   IDLE  | context fresh; next consumed bit is ignored, moves to S0
//   S0    | output 0 branch; din=1 toggles to S1
//   S1    | output 1 branch; din=1 toggles to S0
module mealy_ch_scheduler
  import mealy_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_valid,
  input  logic [NCH-1:0] req_din,
  input  logic [NCH-1:0] ch_clr,
  output logic [NCH-1:0] gnt,
  output logic           res_valid,
  output logic [CW-1:0]  res_ch,
  output logic           res_dout
);

  logic [SW-1:0]  ctx_q [NCH];
  logic [SW-1:0]  ctx_d [NCH];
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  gidx;
  logic           any_gnt;
  logic [NCH-1:0] elig;
  logic [SW-1:0]  step_next;
  logic           step_dout;
  logic           res_valid_q;
  logic [CW-1:0]  res_ch_q;
  logic           res_dout_q;

  assign elig = req_valid & ~ch_clr;

  // Arbiter: scan from ptr with manual wrap so indices >= NCH are never produced.
  always_comb begin
    logic [CW:0] sum;
    gnt     = '0;
    gidx    = '0;
    any_gnt = 1'b0;
    sum     = '0;
    if (!rst) begin
      for (int o = 0; o < NCH; o++) begin
        sum = {1'b0, ptr_q} + (CW+1)'(o);
        if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
        if (!any_gnt && elig[sum[CW-1:0]]) begin
          any_gnt            = 1'b1;
          gidx               = sum[CW-1:0];
          gnt[sum[CW-1:0]]   = 1'b1;
        end
      end
    end
  end

  mealy_step u_step (
    .state_i (ctx_q[gidx]),
    .din_i   (req_din[gidx]),
    .next_o  (step_next),
    .dout_o  (step_dout)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) ptr_d = (gidx == CW'(NCH-1)) ? '0 : gidx + CW'(1);
    for (int i = 0; i < NCH; i++) begin
      ctx_d[i] = ctx_q[i];
      if (ch_clr[i])   ctx_d[i] = ST_IDLE;
      else if (gnt[i]) ctx_d[i] = step_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_dout_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) ctx_q[i] <= ST_RST;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= any_gnt;
      if (any_gnt) begin
        res_ch_q   <= gidx;
        res_dout_q <= step_dout;
      end
      for (int i = 0; i < NCH; i++) ctx_q[i] <= ctx_d[i];
    end
  end

  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_dout  = res_dout_q;

endmodule

// File: doc/mealy_ch_scheduler.md
# mealy_ch_scheduler

Time-multiplexes one shared 3-state Mealy transition/output function across NCH independent serial bit channels. Per-channel FSM context is held in a small register array, and a round-robin arbiter picks one channel per cycle. The granted bit is applied to that channel's stored context, and a tagged, registered result is emitted one cycle later. The block sits between the per-channel serial front ends and the result collector, replacing NCH copies of the single-channel FSM.

## Interface
- NCH, 4: number of channels, 2..16.
- CW, $clog2(NCH): channel index width, derived, not overridden.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NCH  channel i has a bit to process.
- req_din  in  NCH  data bit of channel i, sampled when granted.
- ch_clr  in  NCH  force channel i context to IDLE at next edge.
- gnt  out  NCH  one-hot, combinational; gnt[i]=1 means req_din[i] is consumed this cycle.
- res_valid  out  1  registered result strobe.
- res_ch  out  CW  channel index of the result.
- res_dout  out  1  Mealy output for the consumed bit.

## Operation
- Context states, 2 bits: IDLE=0, S0=1, S1=2; 3 is illegal.
- Step function (state, din -> next, dout):
  - IDLE: -> S0, dout 0, din ignored but consumed.
  - S0: din=1 -> S1; din=0 -> S0; dout 0.
  - S1: din=1 -> S0; din=0 -> S1; dout 1.
  - Illegal: -> IDLE, dout 0.
- Eligible mask: req_valid & ~ch_clr. Channels under clear are never granted.
- Round-robin: pointer ptr (CW bits) names the highest-priority channel. Scan ptr, ptr+1, … mod NCH; the first eligible channel is granted.
  - After a grant to k: ptr <= (k+1) mod NCH.
  - With no grant, ptr holds.
- At most one gnt bit is high per cycle. gnt is all-zero while rst=1 or when nothing is eligible.
- On grant to k: ctx[k] <= next; res_valid <= 1; res_ch <= k; res_dout <= dout.
- With no grant: res_valid <= 0; res_ch and res_dout hold their previous values.
- ch_clr[i]: ctx[i] <= IDLE. This has no effect on ptr or on other channels. Multiple clears in the same cycle are allowed.
- Ungranted channels keep their context unchanged.

## Timing
- Reset values: every ctx = IDLE, ptr = 0, res_valid = 0, res_ch = 0, res_dout = 0, gnt = 0.
- Requesters hold req_valid/req_din until they see gnt.
- Latency: a grant in cycle t produces res_* valid in cycle t+1. Throughput is one bit per cycle in aggregate.
- Back-to-back grants to the same channel are legal only when it is the sole eligible channel. In that case the second step uses the context already updated at the t+1 edge, so there is no hazard.
- rst asserted mid-stream: the in-flight result is dropped (res_valid=0 next cycle) and all contexts return to IDLE.
- ch_clr[i] while res for i is in flight: the result is still delivered, and the context is IDLE afterwards.
- NCH not a power of two: ptr wraps from NCH-1 to 0, and indices ≥ NCH are never granted.

## Structure
- Shared package `mealy_pkg`: the state localparams (IDLE/S0/S1), the 2-bit state width constant, and a reset-state constant.
- Sub-module `mealy_step`: purely combinational (state, din) -> (next, dout). It is instantiated once and fed by a mux on ctx[granted].
- Top level: context array, round-robin arbiter (double-width mask-and-priority or loop scan), result register, ptr register.

## Test plan
- Reset then idle: rst 2 cycles, all req_valid=0 -> gnt=0, res_valid=0, res_ch=0, res_dout=0, for 5 cycles.
- Single channel sequence: only ch0 valid with din 0,1,0,1,1. Required res_dout sequence 0,0,1,1,0. Context sequence S0,S1,S1,S0,S1. res_ch=0 throughout, back-to-back.
- Fairness: all 4 channels valid continuously -> gnt order ch0,ch1,ch2,ch3,ch0,…. Each channel is granted exactly once per 4 cycles.
- Sparse requests: ptr=2 with only ch0 and ch3 valid -> ch3 granted, then ch0, then ch3.
- Clear collision: ch1 in S1 with ch_clr[1]=1 and req_valid[1]=1 in the same cycle -> gnt[1]=0 that cycle. The next grant to ch1 yields dout 0 (IDLE step).
- Mid-stream reset: ch2 granted in cycle t, rst in cycle t -> res_valid=0 at t+1. A subsequent ch2 step yields dout 0 and next state S0.
